fpu_mul_arbiter: RTL
====================

// Module: fpu_mul_arbiter
// PURPOSE
//  Shares one fixed-latency, fully pipelined FP32 multiplier (FPU_MUL) among
//  N_REQ requesters (the FFT butterfly/twiddle units) with round-robin fairness.
//  - Accepts operand pairs over valid/ready and issues at most one per cycle.
//  - Tags every issue with its requester ID.
//  - Routes each result back to the requester that issued it, in issue order.
// PARAMETERS
//  N_REQ      4   number of requesters (>=2)
//  SIZE_DATA  32  operand/result width (IEEE-754 single)
//  MUL_LAT    3   multiplier latency: i_mul_result valid MUL_LAT cycles after o_mul_valid
// PORTS
//  i_clk            in   1                clock; all logic on rising edge
//  i_rst            in   1                reset, synchronous, active-high
//  i_req_valid      in   N_REQ            per-requester operand pair valid
//  o_req_ready      out  N_REQ            one-hot grant; handshake = valid & ready
//  i_req_a          in   N_REQ*SIZE_DATA  operand A, requester k in bits [k*SIZE_DATA +: SIZE_DATA]
//  i_req_b          in   N_REQ*SIZE_DATA  operand B, same packing as i_req_a
//  o_mul_valid      out  1                issue strobe to the multiplier
//  o_mul_a          out  SIZE_DATA        operand A to the multiplier
//  o_mul_b          out  SIZE_DATA        operand B to the multiplier
//  i_mul_result     in   SIZE_DATA        multiplier product (no valid; fixed latency)
//  o_rsp_valid      out  N_REQ            one-hot response strobe, no backpressure
//  o_rsp_data       out  SIZE_DATA        product, shared by all requesters
//  o_busy           out  1                any operation in flight
//  o_perf_grant_cnt out  N_REQ*16         only with FPU_MUL_ARB_PERF_EN
// BEHAVIOUR
//  - Reset values:
//    - o_mul_valid, o_rsp_valid, o_busy = 0; o_mul_a/b, o_rsp_data = 0.
//    - RR pointer = 0; tag pipeline cleared.
//  - Grant (combinational):
//    - Scan i_req_valid starting at the pointer, wrapping N_REQ-1 -> 0.
//    - The first valid requester found gets o_req_ready.
//    - o_req_ready = 0 while i_rst = 1.
//    - o_req_ready never depends on i_req_a or i_req_b.
//  - Pointer:
//    - After a grant to k, pointer <= (k+1) mod N_REQ.
//    - With no grant, the pointer holds.
//  - Issue: a handshake in cycle t registers the operands.
//    - o_mul_valid=1 and o_mul_a/b carry them in cycle t+1.
//    - With no handshake, o_mul_valid=0; o_mul_a/b hold their last value.
//  - Tag pipeline: MUL_LAT+1 stages of {valid, id[$clog2(N_REQ)-1:0]}.
//    - Advances every cycle; there is no stall.
//  - Response:
//    - Registered in cycle t+1+MUL_LAT from i_mul_result.
//    - o_rsp_valid[id] = 1 in cycle t+2+MUL_LAT.
//    - Total latency is MUL_LAT+2 cycles from handshake.
//    - Responses are one-hot and follow issue order.
//    - o_rsp_data holds its value when no response is valid.
//  - Throughput: 1 op/cycle sustained, from one requester or many.
//  - o_busy = OR of the tag-valid bits and o_mul_valid.
//  - Reset mid-operation:
//    - Every in-flight tag is dropped.
//    - No o_rsp_valid is asserted for ops issued before reset.
//    - A result still emerging from the multiplier is ignored.
//  - No requester valid: no issue; the pipeline drains normally.
// CONFIGURATION
//  FPU_MUL_ARB_PERF_EN defined:
//    - One 16-bit saturating grant counter per requester; it stops at 0xFFFF.
//    - Each counter increments on that requester's handshake.
//    - Counters clear on i_rst; driven on o_perf_grant_cnt.
//  FPU_MUL_ARB_PERF_EN undefined:
//    - Counters and port absent; behaviour otherwise identical.
// STRUCTURE
//  - Package fpu_mul_arb_pkg holds:
//    - localparam ID_W = $clog2(N_REQ), derived from the default N_REQ.
//    - typedef struct packed {logic vld; logic [ID_W-1:0] id;} arb_tag_t.
//    - localparam PERF_W = 16.
//  - Sub-module rr_arbiter (N param):
//    - Inputs: i_req, i_ptr. Output: o_gnt (one-hot).
//    - Purely combinational.
//    - The top owns the pointer register, the operand registers, the tag
//      pipeline and the response register.
// TESTING (MUL_LAT=3 -> latency 5; multiplier model = ideal FP32 multiply, 3-cycle delay)
//  1. Req0 only: a=0x3F800000, b=0x40000000 -> o_rsp_valid=4'b0001 with
//     o_rsp_data=0x40000000 exactly 5 cycles after handshake; o_busy low afterwards.
//  2. All four valid for 8 cycles -> grants 0,1,2,3,0,1,2,3 one per cycle;
//     responses in the same order, back-to-back.
//  3. Pointer at 2, only req1 and req3 valid -> grant req3, then req1; pointer ends at 2.
//  4. Req2 held valid for 10 cycles alone -> 10 handshakes on consecutive cycles,
//     10 consecutive o_rsp_valid=4'b0100.
//  5. i_rst pulsed 1 cycle with 3 ops in flight -> no o_rsp_valid for 6 cycles;
//     pointer=0; next grant goes to the lowest valid index.
//  6. PERF_EN: 70000 handshakes on req0 -> o_perf_grant_cnt[15:0]=0xFFFF,
//     other counters 0; i_rst clears all counters to 0.

Source files
------------

// File: rtl/fpu_mul_arb_pkg.sv
// Shared types and constants for the FP32 multiplier arbiter.
// The ID width is derived from the default requester count of 4.
package fpu_mul_arb_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int ID_W      = $clog2(N_REQ_DEF);
  localparam int PERF_W    = 16;

  // One entry of the in-flight tag pipeline: valid plus issuing requester ID.
  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } arb_tag_t;

endpackage

// File: rtl/fpu_mul_arbiter_rr_arbiter.sv
// Combinational round-robin grant: scans i_req starting at i_ptr, wrapping
// from N-1 to 0, and grants the first requester found (one-hot or zero).
// i_ptr must be below N; the owner of the pointer guarantees that.
module rr_arbiter #(
  parameter int N = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt
);

  logic [2*N-1:0] w_req_dbl;
  logic [2*N-1:0] w_gnt_dbl;
  logic [N-1:0]   w_req_rot;
  logic [N-1:0]   w_first;
  logic           w_found;

  // Rotate requests right so that bit 0 is the requester at the pointer.
  assign w_req_dbl = {i_req, i_req} >> i_ptr;
  assign w_req_rot = w_req_dbl[N-1:0];

  // Fixed-priority pick of the lowest set bit in the rotated request vector.
  always_comb begin
    w_first = '0;
    w_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (w_req_rot[i] && !w_found) begin
        w_first[i] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

  // Rotate the winner back left into absolute requester positions.
  assign w_gnt_dbl = {w_first, w_first} << i_ptr;
  assign o_gnt     = w_gnt_dbl[2*N-1:N];

endmodule

// File: rtl/fpu_mul_arbiter.sv
// Shares one fixed-latency pipelined FP32 multiplier among N_REQ requesters
// with round-robin fairness. A handshake in cycle t issues in cycle t+1; the
// product returns to the issuing requester in cycle t+2+MUL_LAT, in issue order.
// Optional per-requester saturating grant counters: FPU_MUL_ARB_PERF_EN.
//
// Handshake: a requester's operand pair transfers in any cycle where
// i_req_valid[k] & o_req_ready[k]; ready is one-hot, never depends on the
// operand data, and is low during reset. Responses have no backpressure.
module fpu_mul_arbiter
  import fpu_mul_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int SIZE_DATA = 32,
  parameter int MUL_LAT   = 3
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [N_REQ-1:0]           i_req_valid,
  output logic [N_REQ-1:0]           o_req_ready,
  input  logic [N_REQ*SIZE_DATA-1:0] i_req_a,
  input  logic [N_REQ*SIZE_DATA-1:0] i_req_b,
  output logic                       o_mul_valid,
  output logic [SIZE_DATA-1:0]       o_mul_a,
  output logic [SIZE_DATA-1:0]       o_mul_b,
  input  logic [SIZE_DATA-1:0]       i_mul_result,
  output logic [N_REQ-1:0]           o_rsp_valid,
  output logic [SIZE_DATA-1:0]       o_rsp_data,
  output logic                       o_busy
`ifdef FPU_MUL_ARB_PERF_EN
  ,
  output logic [N_REQ*PERF_W-1:0]    o_perf_grant_cnt
`endif
);

  logic [N_REQ-1:0]     w_gnt;
  logic                 w_hs;
  logic [ID_W-1:0]      w_hs_id;
  logic [SIZE_DATA-1:0] w_sel_a;
  logic [SIZE_DATA-1:0] w_sel_b;
  logic                 w_busy;

  logic [ID_W-1:0]      r_ptr;
  logic                 r_mul_valid;
  logic [SIZE_DATA-1:0] r_mul_a;
  logic [SIZE_DATA-1:0] r_mul_b;
  arb_tag_t             r_tag [MUL_LAT+1];
  logic [N_REQ-1:0]     r_rsp_valid;
  logic [SIZE_DATA-1:0] r_rsp_data;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .i_req (i_req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt)
  );

  // Grants are suppressed while reset is held so nothing is accepted then.
  assign o_req_ready = i_rst ? '0 : w_gnt;
  assign w_hs        = |(o_req_ready & i_req_valid);

  // Encode the granted requester and pick its operand pair.
  always_comb begin
    w_hs_id = '0;
    w_sel_a = '0;
    w_sel_b = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (o_req_ready[k] && i_req_valid[k]) begin
        w_hs_id = ID_W'(k);
        w_sel_a = i_req_a[k*SIZE_DATA +: SIZE_DATA];
        w_sel_b = i_req_b[k*SIZE_DATA +: SIZE_DATA];
      end
    end
  end

  // Round-robin pointer moves just past the last winner; holds when idle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (w_hs) begin
      r_ptr <= (w_hs_id == ID_W'(N_REQ - 1)) ? '0 : w_hs_id + 1'b1;
    end
  end

  // Issue register: operands go to the multiplier the cycle after handshake.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mul_valid <= 1'b0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
    end else begin
      r_mul_valid <= w_hs;
      if (w_hs) begin
        r_mul_a <= w_sel_a;
        r_mul_b <= w_sel_b;
      end
    end
  end

  // Tag pipeline tracks who owns each multiplier stage; it never stalls.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int s = 0; s <= MUL_LAT; s++) begin
        r_tag[s] <= '0;
      end
    end else begin
      r_tag[0].vld <= w_hs;
      r_tag[0].id  <= w_hs_id;
      for (int s = 1; s <= MUL_LAT; s++) begin
        r_tag[s] <= r_tag[s-1];
      end
    end
  end

  // Capture the product when the last tag stage is valid and strobe its owner.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= '0;
      if (r_tag[MUL_LAT].vld) begin
        r_rsp_valid <= N_REQ'(1) << r_tag[MUL_LAT].id;
        r_rsp_data  <= i_mul_result;
      end
    end
  end

  // Busy while anything sits in the issue register or the tag pipeline.
  always_comb begin
    w_busy = r_mul_valid;
    for (int s = 0; s <= MUL_LAT; s++) begin
      w_busy = w_busy | r_tag[s].vld;
    end
  end

  assign o_mul_valid = r_mul_valid;
  assign o_mul_a     = r_mul_a;
  assign o_mul_b     = r_mul_b;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_busy      = w_busy;

`ifdef FPU_MUL_ARB_PERF_EN
  logic [PERF_W-1:0] r_perf_cnt [N_REQ];

  // Per-requester grant counters that stick at all-ones.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < N_REQ; k++) begin
        r_perf_cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        if (o_req_ready[k] && i_req_valid[k] && (r_perf_cnt[k] != '1)) begin
          r_perf_cnt[k] <= r_perf_cnt[k] + 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_perf
    assign o_perf_grant_cnt[g*PERF_W +: PERF_W] = r_perf_cnt[g];
  end
`endif

endmodule
